// File: rtl/port_allocator.sv
// port_allocator: per-output wormhole lock allocator for a 5-port router.
//
// Each output runs a small IDLE/LOCKED FSM. An IDLE output grants the first
// eligible header in round-robin order from its pointer. While LOCKED, the
// output forwards the owner's head flit each cycle it is present. It releases
// after the tail is popped, and the pointer then moves just past the owner.
//
// Port order for inputs and outputs: N=0, E=1, W=2, S=3, L=4.
// Flit type encoding on flit_id: HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100.
//
// Optional build macro LOCK_TIMEOUT_EN: if the owner stays empty for 15
// consecutive locked cycles, the lock is dropped as if the tail had been seen.
//
// state  | meaning
// IDLE   | output free; may grant a header this cycle, lock from next cycle
// LOCKED | output owned by owner_q; forwards owner's flits until its tail

module port_allocator (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  empty,
  input  logic [14:0] flit_id,
  input  logic [24:0] req,
  output logic [24:0] grant,
  output logic [4:0]  rd_en,
  output logic [4:0]  out_valid
);

  localparam int N_PORTS = 5;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t     state_q [N_PORTS];
  state_t     state_d [N_PORTS];
  logic [2:0] owner_q [N_PORTS];
  logic [2:0] owner_d [N_PORTS];
  logic [2:0] ptr_q   [N_PORTS];
  logic [2:0] ptr_d   [N_PORTS];

`ifdef LOCK_TIMEOUT_EN
  logic [3:0] cnt_q [N_PORTS];
  logic [3:0] cnt_d [N_PORTS];
`endif

  logic [2:0]  head_type [N_PORTS];
  logic [4:0]  req_low   [N_PORTS];
  logic [4:0]  busy_in;
  logic [4:0]  cand      [N_PORTS];
  logic [2:0]  pick      [N_PORTS];
  logic [4:0]  pick_vld;
  logic [24:0] grant_d;

  // Pointer value used after the owner releases: one past it, wrapping 4 to 0.
  function automatic logic [2:0] next_ptr(input logic [2:0] o);
    return (o == 3'd4) ? 3'd0 : o + 3'd1;
  endfunction

  // Split the head flit type per input; keep only the lowest requested output per row.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      head_type[i] = flit_id[3*i +: 3];
      req_low[i]   = req[5*i +: 5] & (~req[5*i +: 5] + 5'd1);
    end
  end

  // An input that already owns a locked output cannot start another packet.
  always_comb begin
    busy_in = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (state_q[j] == ST_LOCKED && owner_q[j] == 3'(i)) begin
          busy_in[i] = 1'b1;
        end
      end
    end
  end

  // Candidate matrix and round-robin pick starting at each output's pointer.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      pick[j] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cand[j][i] = !empty[i] && (head_type[i] == FLIT_HEADER) &&
                     req_low[i][j] && !busy_in[i];
      end
      for (int k = 0; k < N_PORTS; k++) begin
        idx = int'(ptr_q[j]) + k;
        if (idx >= N_PORTS) begin
          idx = idx - N_PORTS;
        end
        if (!pick_vld[j] && cand[j][idx]) begin
          pick[j]     = 3'(idx);
          pick_vld[j] = 1'b1;
        end
      end
    end
  end

  // Per-output FSM next state plus the combinational pop/forward strobes.
  always_comb begin
    rd_en     = '0;
    out_valid = '0;
    grant_d   = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
`ifdef LOCK_TIMEOUT_EN
      cnt_d[j]   = '0;
`endif
      case (state_q[j])
        ST_IDLE: begin
          if (pick_vld[j]) begin
            state_d[j] = ST_LOCKED;
            owner_d[j] = pick[j];
          end
        end
        ST_LOCKED: begin
          if (!empty[owner_q[j]]) begin
            rd_en[owner_q[j]] = 1'b1;
            out_valid[j]      = 1'b1;
            if (head_type[owner_q[j]] == FLIT_TAIL) begin
              state_d[j] = ST_IDLE;
              ptr_d[j]   = next_ptr(owner_q[j]);
            end
          end
`ifdef LOCK_TIMEOUT_EN
          else begin
            // Release on the stalled cycle that brings the count to 15.
            cnt_d[j] = (cnt_q[j] == 4'd15) ? 4'd15 : cnt_q[j] + 4'd1;
            if (cnt_q[j] == 4'd14) begin
              state_d[j] = ST_IDLE;
              ptr_d[j]   = next_ptr(owner_q[j]);
            end
          end
`endif
        end
        default: begin
          state_d[j] = ST_IDLE;
        end
      endcase
      for (int i = 0; i < N_PORTS; i++) begin
        grant_d[5*i + j] = (state_d[j] == ST_LOCKED) && (owner_d[j] == 3'(i));
      end
    end
    if (rst) begin
      rd_en     = '0;
      out_valid = '0;
    end
  end

  // State, owner, pointer and registered grant matrix; reset aborts any packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_PORTS; j++) begin
        state_q[j] <= ST_IDLE;
        owner_q[j] <= '0;
        ptr_q[j]   <= '0;
`ifdef LOCK_TIMEOUT_EN
        cnt_q[j]   <= '0;
`endif
      end
      grant <= '0;
    end else begin
      for (int j = 0; j < N_PORTS; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
`ifdef LOCK_TIMEOUT_EN
        cnt_q[j]   <= cnt_d[j];
`endif
      end
      grant <= grant_d;
    end
  end

  // Grant matrix must stay one-hot-or-zero per output column and input row.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_grant_chk
    logic [4:0] col;
    assign col = {grant[20 + g], grant[15 + g], grant[10 + g], grant[5 + g], grant[g]};
    a_col_onehot : assert property (@(posedge clk) $onehot0(col));
    a_row_onehot : assert property (@(posedge clk) $onehot0(grant[5*g +: 5]));
  end

endmodule

// File: tb/tb_port_allocator.sv
// tb_port_allocator: directed-vector bench for port_allocator.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Build with LOCK_TIMEOUT_EN defined to exercise the lock timeout path.

module tb_port_allocator;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] PAY  = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  empty = 5'h1f;
  logic [14:0] flit_id = '0;
  logic [24:0] req = '0;
  logic [24:0] grant;
  logic [4:0]  rd_en;
  logic [4:0]  out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  port_allocator dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .flit_id   (flit_id),
    .req       (req),
    .grant     (grant),
    .rd_en     (rd_en),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] e, input logic [14:0] f, input logic [24:0] r);
    empty   = e;
    flit_id = f;
    req     = r;
    #1;
  endtask

  function automatic logic [14:0] fl(input int i, input logic [2:0] t);
    return 15'(t) << (3*i);
  endfunction

  function automatic logic [24:0] rq(input int i, input int j);
    return 25'd1 << (5*i + j);
  endfunction

  // Two reset edges, then rst drops; the caller's first cycle follows directly.
  task automatic do_reset;
    rst = 1'b1;
    drive(5'h1f, '0, '0);
    tick;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_rd_en", 32'(rd_en), 32'h0);
    tick;
    rst = 1'b0;
  endtask

  logic [24:0] r2;

  initial begin
    // Scenario: W sends a 3-flit packet to E.
    do_reset();
    drive(~5'b00100, fl(2, HDR), rq(2, 1));
    check("s1_c0_grant", 32'(grant), 32'h0);
    check("s1_c0_rd_en", 32'(rd_en), 32'h0);
    check("s1_c0_ov", 32'(out_valid), 32'h0);
    tick;
    drive(~5'b00100, fl(2, HDR), rq(2, 1));
    check("s1_c1_grant", 32'(grant), 32'h800);
    check("s1_c1_rd_en", 32'(rd_en), 32'h04);
    check("s1_c1_ov", 32'(out_valid), 32'h02);
    tick;
    drive(~5'b00100, fl(2, PAY), '0);
    check("s1_c2_rd_en", 32'(rd_en), 32'h04);
    tick;
    drive(~5'b00100, fl(2, TAIL), '0);
    check("s1_c3_rd_en", 32'(rd_en), 32'h04);
    check("s1_c3_grant", 32'(grant), 32'h800);
    tick;
    drive(5'h1f, '0, '0);
    check("s1_rel_grant", 32'(grant), 32'h0);
    check("s1_ptr1", 32'(dut.ptr_q[1]), 32'd3);

    // Scenario: N, S, L contend for output L; round-robin order N, S, L.
    do_reset();
    r2 = rq(0, 4) | rq(3, 4) | rq(4, 4);
    drive(~5'b11001, fl(0, HDR) | fl(3, HDR) | fl(4, HDR), r2);
    check("s2_c0_grant", 32'(grant), 32'h0);
    tick;
    drive(~5'b11001, fl(0, HDR) | fl(3, HDR) | fl(4, HDR), r2);
    check("s2_n_grant", 32'(grant), 32'h10);
    check("s2_n_rd_en", 32'(rd_en), 32'h01);
    check("s2_n_ov", 32'(out_valid), 32'h10);
    tick;
    drive(~5'b11001, fl(0, PAY) | fl(3, HDR) | fl(4, HDR), r2);
    check("s2_n_pay", 32'(rd_en), 32'h01);
    tick;
    drive(~5'b11001, fl(0, TAIL) | fl(3, HDR) | fl(4, HDR), r2);
    check("s2_n_tail", 32'(rd_en), 32'h01);
    tick;
    drive(~5'b11000, fl(3, HDR) | fl(4, HDR), r2);
    check("s2_gap1_grant", 32'(grant), 32'h0);
    check("s2_gap1_rd_en", 32'(rd_en), 32'h0);
    check("s2_ptr4_a", 32'(dut.ptr_q[4]), 32'd1);
    tick;
    drive(~5'b11000, fl(3, HDR) | fl(4, HDR), r2);
    check("s2_s_grant", 32'(grant), 32'h80000);
    check("s2_s_rd_en", 32'(rd_en), 32'h08);
    check("s2_s_ov", 32'(out_valid), 32'h10);
    tick;
    drive(~5'b11000, fl(3, PAY) | fl(4, HDR), r2);
    tick;
    drive(~5'b11000, fl(3, TAIL) | fl(4, HDR), r2);
    check("s2_s_tail", 32'(rd_en), 32'h08);
    tick;
    drive(~5'b10000, fl(4, HDR), r2);
    check("s2_gap2_grant", 32'(grant), 32'h0);
    check("s2_ptr4_b", 32'(dut.ptr_q[4]), 32'd4);
    tick;
    drive(~5'b10000, fl(4, HDR), r2);
    check("s2_l_grant", 32'(grant), 32'h1000000);
    check("s2_l_rd_en", 32'(rd_en), 32'h10);
    tick;
    drive(~5'b10000, fl(4, PAY), r2);
    tick;
    drive(~5'b10000, fl(4, TAIL), r2);
    check("s2_l_tail", 32'(rd_en), 32'h10);
    tick;
    drive(5'h1f, '0, '0);
    check("s2_end_grant", 32'(grant), 32'h0);
    check("s2_ptr4_wrap", 32'(dut.ptr_q[4]), 32'd0);

    // Scenario: payload never locks; E->S packet with a 4-cycle owner stall.
    do_reset();
    drive(~5'b00010, fl(1, PAY), rq(1, 0));
    tick;
    drive(~5'b00010, fl(1, HDR), rq(1, 3));
    check("s3_pay_nolock", 32'(grant), 32'h0);
    tick;
    drive(~5'b00010, fl(1, HDR), rq(1, 3));
    check("s3_grant", 32'(grant), 32'h100);
    check("s3_hdr_ov", 32'(out_valid), 32'h08);
    check("s3_hdr_rd_en", 32'(rd_en), 32'h02);
    tick;
    drive(~5'b00010, fl(1, PAY), '0);
    check("s3_pay1_ov", 32'(out_valid), 32'h08);
    for (int k = 0; k < 4; k++) begin
      tick;
      drive(5'h1f, '0, '0);
      check("s3_stall_ov", 32'(out_valid), 32'h0);
      check("s3_stall_rd_en", 32'(rd_en), 32'h0);
      check("s3_stall_grant", 32'(grant), 32'h100);
    end
    tick;
    drive(~5'b00010, fl(1, PAY), '0);
    check("s3_pay2_ov", 32'(out_valid), 32'h08);
    check("s3_pay2_rd_en", 32'(rd_en), 32'h02);
    tick;
    drive(~5'b00010, fl(1, TAIL), '0);
    check("s3_tail_ov", 32'(out_valid), 32'h08);
    tick;
    drive(5'h1f, '0, '0);
    check("s3_end_grant", 32'(grant), 32'h0);

    // Scenario: reset mid-packet on output E, then N requests N and E together.
    drive(~5'b00100, fl(2, HDR), rq(2, 1));
    tick;
    drive(~5'b00100, fl(2, HDR), rq(2, 1));
    check("s4_grant", 32'(grant), 32'h800);
    tick;
    drive(~5'b00100, fl(2, PAY), '0);
    tick;
    rst = 1'b1;
    drive(~5'b00100, fl(2, PAY), '0);
    check("s4_rst_rd_en", 32'(rd_en), 32'h0);
    check("s4_rst_ov", 32'(out_valid), 32'h0);
    tick;
    drive(~5'b00100, fl(2, PAY), '0);
    check("s4_rst_grant", 32'(grant), 32'h0);
    check("s4_rst_rd_en2", 32'(rd_en), 32'h0);
    check("s4_rst_state", 32'(dut.state_q[1]), 32'd0);
    tick;
    rst = 1'b0;
    drive(~5'b00001, fl(0, HDR), rq(0, 0) | rq(0, 1));
    check("s5_c0_grant", 32'(grant), 32'h0);
    tick;
    drive(~5'b00001, fl(0, HDR), rq(0, 0) | rq(0, 1));
    check("s5_grant_low", 32'(grant), 32'h1);
    check("s5_ov", 32'(out_valid), 32'h01);
    check("s5_rd_en", 32'(rd_en), 32'h01);
    tick;
    drive(~5'b00001, fl(0, TAIL), '0);
    check("s5_tail_ov", 32'(out_valid), 32'h01);
    tick;
    drive(5'h1f, '0, '0);
    check("s5_end_grant", 32'(grant), 32'h0);
    check("s5_ptr0", 32'(dut.ptr_q[0]), 32'd1);
    check("s5_ptr1", 32'(dut.ptr_q[1]), 32'd0);

    // Scenario: S locks W, then stays empty for 15 cycles.
    do_reset();
    drive(~5'b01000, fl(3, HDR), rq(3, 2));
    tick;
    drive(~5'b01000, fl(3, HDR), rq(3, 2));
    check("s6_grant", 32'(grant), 32'h20000);
    for (int k = 0; k < 15; k++) begin
      tick;
      drive(5'h1f, '0, '0);
      check("s6_stall_ov", 32'(out_valid), 32'h0);
    end
    tick;
    drive(~5'b01000, fl(3, TAIL), '0);
`ifdef LOCK_TIMEOUT_EN
    check("s6_to_grant", 32'(grant), 32'h0);
    check("s6_to_ptr2", 32'(dut.ptr_q[2]), 32'd4);
    check("s6_to_tail_ov", 32'(out_valid), 32'h0);
`else
    check("s6_hold_grant", 32'(grant), 32'h20000);
    check("s6_hold_ptr2", 32'(dut.ptr_q[2]), 32'd0);
    check("s6_hold_tail_ov", 32'(out_valid), 32'h04);
`endif
    tick;
    drive(5'h1f, '0, '0);
    check("s6_end_grant", 32'(grant), 32'h0);
    check("s6_end_ptr2", 32'(dut.ptr_q[2]), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/port_allocator.md
PORT_ALLOCATOR -- requirements
Module: port_allocator

Interface
REQ-001 SHALL have the port `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `rst`: input, 1 bit. Reset is synchronous and active-high.
REQ-003 SHALL have the port `empty`: input, 5 bits. Bit i = input FIFO i holds no flit. Input order: N=0, E=1, W=2, S=3, L=4.
REQ-004 SHALL have the port `flit_id`: input, 15 bits. Bits [3i+2:3i] = flit type at the head of input i, using the project HEADER/PAYLOAD/TAIL encodings.
REQ-005 SHALL have the port `req`: input, 25 bits. Bit 5i+j = input i's route computation selects output j. Output order: N=0, E=1, W=2, S=3, L=4.
REQ-006 SHALL have the port `grant`: output, 25 bits, registered. Bit 5i+j = output j is locked to input i.
REQ-007 SHALL have the port `rd_en`: output, 5 bits. Bit i = pop the head flit of input i this cycle.
REQ-008 SHALL have the port `out_valid`: output, 5 bits. Bit j = output j forwards a flit this cycle.

Function
REQ-009 Each output j SHALL hold a two-state FSM (IDLE, LOCKED) plus a 3-bit owner register and a 3-bit round-robin pointer `ptr[j]` with range 0..4.
REQ-010 An input i SHALL be a candidate for output j when all of the following hold: `empty[i]`=0; flit type = HEADER; `req[5i+j]`=1; j is the lowest set bit of req row i; input i is not owner of any LOCKED output.
REQ-011 In IDLE with at least one candidate, output j SHALL select the first candidate in circular order starting at `ptr[j]`, enter LOCKED with owner = that input, and assert its grant bit from the next cycle.
REQ-012 Grant-to-request latency SHALL be exactly 1 cycle; the header is popped in the first LOCKED cycle, not the request cycle.
REQ-013 While LOCKED, the following SHALL hold combinationally in the same cycle:
- `rd_en[owner]` = `out_valid[j]` = ~`empty[owner]`;
- an empty owner stalls the output, which stays locked.
REQ-014 When owner is non-empty with flit type TAIL, output j SHALL:
- pop the tail;
- return to IDLE next cycle;
- set `ptr[j]` = (owner+1) mod 5, wrapping 4 to 0.
REQ-015 An output SHALL NOT regrant in its release cycle; at least one IDLE cycle SHALL separate packets on the same output.
REQ-016 When several outputs in IDLE select candidates in the same cycle, each input SHALL be granted to at most one output; since an input's request row resolves to a single output (REQ-010), no conflict arises.
REQ-017 Request bits for a HEADER not yet granted SHALL be ignored until granted; PAYLOAD and TAIL flits SHALL never create new locks.
REQ-018 `rd_en` bits of non-owner inputs SHALL be 0.
REQ-019 `grant` SHALL be one-hot or zero per output column and per input row.

Reset
REQ-020 While `rst`=1 at a clock edge, the block SHALL apply the following at that edge, including mid-packet:
- all FSMs go to IDLE;
- owners and `ptr` are cleared to 0;
- `grant` is cleared to 0.
REQ-021 While `rst` is high, `rd_en` and `out_valid` SHALL be 0 combinationally.
REQ-022 After `rst` falls, the first grant SHALL be possible on the following edge.

Configuration
REQ-023 With `LOCK_TIMEOUT_EN` defined, each output SHALL count consecutive LOCKED cycles with the owner empty, using a 4-bit saturating counter cleared on any pop.
REQ-024 With `LOCK_TIMEOUT_EN` defined, when that count reaches 15 the output SHALL return to IDLE next cycle and advance `ptr` as on tail release.
REQ-025 Without `LOCK_TIMEOUT_EN`, no counter SHALL exist and a lock SHALL persist until tail or reset.

Verification
REQ-026 Scenario: reset, then input W (2) sends HEADER with `req` bit 5·2+1 (output E), then PAYLOAD, then TAIL, continuously non-empty. Required response:
- `grant` bit 11 rises one cycle after the header;
- `rd_en[2]`=1 for 3 cycles;
- release occurs, then `ptr[1]`=3.
REQ-027 Scenario: inputs N, S, L all request output L with `ptr[4]`=0, each sending 3-flit packets. Required response:
- the grant order is N, S, L;
- one IDLE cycle separates consecutive grants;
- after L's tail, `ptr[4]` wraps to 0.
REQ-028 Scenario: owner goes empty for 4 cycles mid-packet. Required response:
- `out_valid` stays 0 for those 4 cycles;
- the lock is held;
- the remaining flits resume in order.
REQ-029 Scenario: `rst` asserted while output E is LOCKED mid-packet. Required response:
- next cycle `grant`=0 and the FSM is IDLE;
- `rd_en`=0 while reset is high.
REQ-030 Scenario: input N sends HEADER with `req` bits 0 and 1 both set. Required response: only output N (0) grants.
REQ-031 Scenario (`LOCK_TIMEOUT_EN` defined): owner empty for 15 cycles after the header. Required response:
- output returns to IDLE;
- `ptr` advances past the owner.

Scenario (`LOCK_TIMEOUT_EN` undefined): same stimulus. Required response: the lock is held.
